audio_frame_sync_gen: RTL and testbench

Derives a clean sample-frame sync strobe from the audio codec's asynchronous LRCK and drives the sync PIO's `in_port`, so software receives one edge-capture interrupt per N audio frames. The block sits between the codec pins and the sync PIO. It synchronises LRCK into `clk`, divides frames by a programmable ratio, and stretches each sync event into a fixed-width pulse. It also reports lock status and frame count.

---
 rtl/audio_frame_sync_gen.sv | 183 ++++++++++++++++++
 tb/tb_audio_frame_sync_gen.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_frame_sync_gen.sv
// audio_frame_sync_gen
//
// Turns the codec's asynchronous LRCK into a clean, fixed-width sync strobe
// for the sync PIO in_port, one strobe per `divider` audio frames. LRCK is
// brought into the clk domain through a two-flop synchroniser and a rising
// edge detector. The edges are divided by a programmable ratio. Each sync
// event is stretched to PULSE_W clk cycles. The block also reports lock
// status and a running count of sync events.
//
// Optional feature: define AUDIO_SYNC_TIMEOUT_EN to build an LRCK-loss
// watchdog. When it is not defined, `timeout` is tied low and `locked` stays
// high from the first enabled LRCK edge until `enable` drops or reset.
//
// Parameters:
//   DIV_W          width of the divider input
//   PULSE_W        sync_out high time in clk cycles (1..255)
//   TIMEOUT_CYCLES clk cycles without an LRCK rise before lock is lost
//
// Ports:
//   clk          in   system clock
//   reset_n      in   asynchronous active-low reset
//   aud_lrck     in   codec LRCK, asynchronous to clk
//   enable       in   1 = generate syncs; 0 clears divider, pulse and lock state
//   divider      in   frames per sync event (0 behaves as 1)
//   sync_out     out  stretched sync pulse to the PIO in_port
//   frame_count  out  number of sync events fired, wraps at 16 bits
//   locked       out  LRCK is present and tracked
//   timeout      out  sticky LRCK-loss flag (watchdog build only)

module audio_frame_sync_gen #(
  parameter int DIV_W          = 8,
  parameter int PULSE_W        = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             aud_lrck,
  input  logic             enable,
  input  logic [DIV_W-1:0] divider,
  output logic             sync_out,
  output logic [15:0]      frame_count,
  output logic             locked,
  output logic             timeout
);

  localparam logic [7:0] PulseLoad = 8'(PULSE_W - 1);

  logic             lrckS1_q, lrckS2_q, lrckD3_q;
  logic             rise;
  logic [DIV_W-1:0] effDiv;
  logic             fire;
  logic             wdogExpire;

  logic [DIV_W-1:0] divCnt_q, divCnt_d;
  logic [7:0]       pulseCnt_q, pulseCnt_d;
  logic             syncOut_q, syncOut_d;
  logic [15:0]      frameCount_q, frameCount_d;
  logic             locked_q, locked_d;

  // Two-flop synchroniser plus one delay stage for edge detection. This runs
  // regardless of enable so that re-enabling never sees a stale edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lrckS1_q <= 1'b0;
      lrckS2_q <= 1'b0;
      lrckD3_q <= 1'b0;
    end else begin
      lrckS1_q <= aud_lrck;
      lrckS2_q <= lrckS1_q;
      lrckD3_q <= lrckS2_q;
    end
  end

  assign rise   = lrckS2_q & ~lrckD3_q;
  assign effDiv = (divider == '0) ? DIV_W'(1) : divider;

  // The >= compare means that lowering divider below the current count
  // fires on the very next edge instead of waiting for the counter to wrap.
  assign fire = enable & rise & (divCnt_q >= (effDiv - DIV_W'(1)));

  // Divider, stretcher, frame counter and lock next-state logic.
  // Disable has priority over everything, including a coincident fire.
  always_comb begin
    divCnt_d     = divCnt_q;
    pulseCnt_d   = pulseCnt_q;
    syncOut_d    = syncOut_q;
    frameCount_d = frameCount_q;
    locked_d     = locked_q;

    if (!enable) begin
      divCnt_d   = '0;
      pulseCnt_d = '0;
      syncOut_d  = 1'b0;
      locked_d   = 1'b0;
    end else begin
      if (rise) begin
        locked_d = 1'b1;
        divCnt_d = fire ? '0 : (divCnt_q + DIV_W'(1));
      end else if (wdogExpire) begin
        locked_d = 1'b0;
        divCnt_d = '0;
      end

      // A fire during a running pulse reloads the counter, so the pulse is
      // extended with no low gap. A watchdog expiry leaves the pulse alone.
      if (fire) begin
        syncOut_d    = 1'b1;
        pulseCnt_d   = PulseLoad;
        frameCount_d = frameCount_q + 16'd1;
      end else if (pulseCnt_q != 8'd0) begin
        pulseCnt_d = pulseCnt_q - 8'd1;
      end else begin
        syncOut_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      divCnt_q     <= '0;
      pulseCnt_q   <= '0;
      syncOut_q    <= 1'b0;
      frameCount_q <= '0;
      locked_q     <= 1'b0;
    end else begin
      divCnt_q     <= divCnt_d;
      pulseCnt_q   <= pulseCnt_d;
      syncOut_q    <= syncOut_d;
      frameCount_q <= frameCount_d;
      locked_q     <= locked_d;
    end
  end

  assign sync_out    = syncOut_q;
  assign frame_count = frameCount_q;
  assign locked      = locked_q;

`ifdef AUDIO_SYNC_TIMEOUT_EN
  localparam int WdogW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WdogW-1:0] WdogLimit = WdogW'(TIMEOUT_CYCLES);

  logic [WdogW-1:0] wdogCnt_q, wdogCnt_d;
  logic             timeout_q, timeout_d;

  // The watchdog counts only while locked. It expires on the edge where the
  // count reaches the limit, then holds there because locked drops. A rise
  // in the same cycle wins and restarts the count instead.
  always_comb begin
    wdogCnt_d  = wdogCnt_q;
    timeout_d  = timeout_q;
    wdogExpire = 1'b0;
    if (!enable) begin
      wdogCnt_d = '0;
      timeout_d = 1'b0;
    end else if (rise) begin
      wdogCnt_d = '0;
      timeout_d = 1'b0;
    end else if (locked_q && (wdogCnt_q != WdogLimit)) begin
      wdogCnt_d = wdogCnt_q + WdogW'(1);
      if (wdogCnt_d == WdogLimit) begin
        wdogExpire = 1'b1;
        timeout_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdogCnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdogCnt_q <= wdogCnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign wdogExpire = 1'b0;
  assign timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_audio_frame_sync_gen.sv
// tb_audio_frame_sync_gen
//
// Directed bench for audio_frame_sync_gen. Two instances share the stimulus:
// dut uses PULSE_W=4 for pulse width and count checks, and dutLong uses
// PULSE_W=50 so that a 40-cycle LRCK period retriggers its pulse. Both use
// TIMEOUT_CYCLES=100. The watchdog expectations follow AUDIO_SYNC_TIMEOUT_EN.

module tb_audio_frame_sync_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        aud_lrck;
  logic        enable;
  logic [7:0]  divider;
  logic        sync_out, locked, timeout;
  logic [15:0] frame_count;
  logic        syncLong, lockedLong, timeoutLong;
  logic [15:0] frameCountLong;

  int checks = 0;
  int errors = 0;

`ifdef AUDIO_SYNC_TIMEOUT_EN
  localparam bit WdogOn = 1'b1;
`else
  localparam bit WdogOn = 1'b0;
`endif

  always #5 clk = ~clk;

  audio_frame_sync_gen #(.DIV_W(8), .PULSE_W(4), .TIMEOUT_CYCLES(100)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .aud_lrck    (aud_lrck),
    .enable      (enable),
    .divider     (divider),
    .sync_out    (sync_out),
    .frame_count (frame_count),
    .locked      (locked),
    .timeout     (timeout)
  );

  audio_frame_sync_gen #(.DIV_W(8), .PULSE_W(50), .TIMEOUT_CYCLES(100)) dutLong (
    .clk         (clk),
    .reset_n     (reset_n),
    .aud_lrck    (aud_lrck),
    .enable      (enable),
    .divider     (divider),
    .sync_out    (syncLong),
    .frame_count (frameCountLong),
    .locked      (lockedLong),
    .timeout     (timeoutLong)
  );

  // Pulse monitor for dut: counts sync_out pulses and any pulse whose high
  // time is not 4 cycles. Also counts low samples of dutLong while watched.
  int   pulses   = 0;
  int   badWidth = 0;
  int   runLen   = 0;
  logic prevSync = 1'b0;
  bit   watchLong = 1'b0;
  int   lowsLong  = 0;

  always @(negedge clk) begin
    if (sync_out && !prevSync) pulses <= pulses + 1;
    if (sync_out) begin
      runLen <= runLen + 1;
    end else if (prevSync) begin
      if (runLen != 4) badWidth <= badWidth + 1;
      runLen <= 0;
    end
    prevSync <= sync_out;
    if (watchLong && !syncLong) lowsLong <= lowsLong + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drives n LRCK periods, each starting with a rise on a falling clk edge.
  task automatic applyStimulus(input int n, input int highCyc, input int lowCyc);
    repeat (n) begin
      @(negedge clk);
      aud_lrck = 1'b1;
      repeat (highCyc - 1) @(negedge clk);
      aud_lrck = 1'b0;
      repeat (lowCyc) @(negedge clk);
    end
  endtask

  int expDiv3 [9] = '{5, 5, 6, 6, 6, 7, 7, 7, 8};

  initial begin
    $display("[TB] start");
    reset_n  = 1'b0;
    aud_lrck = 1'b0;
    enable   = 1'b0;
    divider  = 8'd1;
    repeat (3) @(negedge clk);
    checkOutput("reset sync_out", sync_out, 0);
    checkOutput("reset frame_count", frame_count, 0);
    checkOutput("reset locked", locked, 0);
    checkOutput("reset timeout", timeout, 0);
    reset_n = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    repeat (2) @(negedge clk);

    // Pulse count, divider=1, LRCK period 40: first rise checked cycle by cycle.
    $display("[TB] pulse count");
    aud_lrck = 1'b1;
    repeat (2) @(posedge clk);
    #1 checkOutput("latency N+1 sync_out", sync_out, 0);
    @(posedge clk);
    #1 checkOutput("latency N+2 sync_out", sync_out, 1);
    checkOutput("latency N+2 frame_count", frame_count, 1);
    checkOutput("latency N+2 locked", locked, 1);
    checkOutput("long first sync", syncLong, 1);
    watchLong = 1'b1;
    repeat (3) @(posedge clk);
    #1 checkOutput("pulse last high cycle", sync_out, 1);
    @(posedge clk);
    #1 checkOutput("pulse ends", sync_out, 0);
    repeat (14) @(negedge clk);
    aud_lrck = 1'b0;
    repeat (19) @(negedge clk);
    applyStimulus(4, 20, 20);
    watchLong = 1'b0;
    checkOutput("pulse count", pulses, 5);
    checkOutput("pulse widths wrong", badWidth, 0);
    checkOutput("frame_count after 5", frame_count, 5);
    checkOutput("locked after 5", locked, 1);
    checkOutput("timeout after 5", timeout, 0);

    // Retrigger: dutLong never dropped and its last fire is extended to 50 cycles.
    $display("[TB] retrigger");
    checkOutput("long low samples", lowsLong, 0);
    checkOutput("long frame_count", frameCountLong, 5);
    repeat (13) @(posedge clk);
    #1 checkOutput("long extended high", syncLong, 1);
    @(posedge clk);
    #1 checkOutput("long extended ends", syncLong, 0);

    // Divider 3, then clamp of 0 to 1.
    $display("[TB] divider");
    divider = 8'd3;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1, 20, 20);
      checkOutput($sformatf("div3 rise %0d", i + 1), frame_count, expDiv3[i]);
    end
    divider = 8'd0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 20, 20);
      checkOutput($sformatf("div0 rise %0d", i + 1), frame_count, 9 + i);
    end

    // Divider lowered from 8 to 2 after 5 rises fires on rise 6.
    divider = 8'd8;
    applyStimulus(5, 20, 20);
    checkOutput("div8 five rises", frame_count, 11);
    divider = 8'd2;
    applyStimulus(1, 20, 20);
    checkOutput("lowered fires rise 6", frame_count, 12);
    applyStimulus(1, 20, 20);
    checkOutput("div2 rise 7", frame_count, 12);
    applyStimulus(1, 20, 20);
    checkOutput("div2 rise 8", frame_count, 13);

    // Frame counter wrap from a preloaded 0xFFFF.
    $display("[TB] wrap");
    divider = 8'd1;
    @(negedge clk);
    force dut.frameCount_q = 16'hFFFF;
    @(negedge clk);
    release dut.frameCount_q;
    @(negedge clk);
    checkOutput("preload", frame_count, 16'hFFFF);
    applyStimulus(1, 20, 20);
    checkOutput("wrap to 0", frame_count, 0);
    applyStimulus(1, 20, 20);
    checkOutput("after wrap", frame_count, 1);

    // LRCK stops after one more rise: watchdog expiry exactly 100 cycles later.
    $display("[TB] lrck loss");
    @(negedge clk);
    aud_lrck = 1'b1;
    repeat (3) @(posedge clk);
    #1 aud_lrck = 1'b0;
    checkOutput("last rise frame_count", frame_count, 2);
    repeat (99) @(posedge clk);
    #1 checkOutput("99 cycles timeout", timeout, 0);
    checkOutput("99 cycles locked", locked, 1);
    @(posedge clk);
    #1 checkOutput("100 cycles timeout", timeout, WdogOn);
    checkOutput("100 cycles locked", locked, !WdogOn);
    repeat (20) @(posedge clk);
    #1 checkOutput("timeout sticky", timeout, WdogOn);

    // Restart: relock on first rise, first fire after 3 rises with divider 3.
    divider = 8'd3;
    @(negedge clk);
    aud_lrck = 1'b1;
    repeat (3) @(posedge clk);
    #1 checkOutput("restart locked", locked, 1);
    checkOutput("restart timeout", timeout, 0);
    checkOutput("restart rise 1 count", frame_count, 2);
    repeat (17) @(negedge clk);
    aud_lrck = 1'b0;
    repeat (19) @(negedge clk);
    applyStimulus(1, 20, 20);
    checkOutput("restart rise 2 count", frame_count, 2);
    applyStimulus(1, 20, 20);
    checkOutput("restart rise 3 count", frame_count, 3);

    // Disable mid-pulse.
    $display("[TB] disable");
    divider = 8'd1;
    @(negedge clk);
    aud_lrck = 1'b1;
    repeat (3) @(posedge clk);
    #1 checkOutput("pre-disable sync", sync_out, 1);
    checkOutput("pre-disable count", frame_count, 4);
    aud_lrck = 1'b0;
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    #1 checkOutput("disable sync_out", sync_out, 0);
    checkOutput("disable locked", locked, 0);
    checkOutput("disable timeout", timeout, 0);
    checkOutput("disable count held", frame_count, 4);
    applyStimulus(2, 20, 20);
    checkOutput("disabled rises count", frame_count, 4);
    checkOutput("disabled rises sync", sync_out, 0);

    // Enable falls in the cycle a fire would happen: no pulse, no count.
    @(negedge clk);
    enable   = 1'b1;
    aud_lrck = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    #1 checkOutput("fire vs disable sync", sync_out, 0);
    checkOutput("fire vs disable count", frame_count, 4);
    aud_lrck = 1'b0;

    // Asynchronous reset in the middle of a pulse.
    $display("[TB] async reset");
    @(negedge clk);
    enable = 1'b1;
    repeat (3) @(negedge clk);
    aud_lrck = 1'b1;
    repeat (3) @(posedge clk);
    #1 checkOutput("pre-reset sync", sync_out, 1);
    checkOutput("pre-reset count", frame_count, 5);
    #2 reset_n = 1'b0;
    #1 checkOutput("async reset sync_out", sync_out, 0);
    checkOutput("async reset frame_count", frame_count, 0);
    checkOutput("async reset locked", locked, 0);
    checkOutput("async reset timeout", timeout, 0);
    #20;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
